somador_serial_ctrl: RTL and testbench
======================================

Name: somador_serial_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands nibble-serially, LSB nibble first, through one shared external somador4Bits instance.
- somador4Bits has no carry-in, so the controller propagates carry itself: when a carry is pending, it spends a second adder pass adding 1 to the partial nibble.
- Sits between a requester (START/DONE handshake) and the 4-bit adder datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam; not overridable.

Ports:
- CLK  input  1  clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured when START is accepted.
- B  input  WIDTH  operand B; captured when START is accepted.
- BUSY  output  1  high while in ADD or INC.
- DONE  output  1  one-cycle pulse; S and CARRY_OUT are valid.
- S  output  WIDTH  sum; held stable until the next accepted START.
- CARRY_OUT  output  1  carry out of the MSB nibble; held stable with S.
- ADD_A  output  4  operand A to somador4Bits.
- ADD_B  output  4  operand B to somador4Bits.
- ADD_C  input  4  sum from somador4Bits (combinational).
- ADD_CARRY  input  1  CARRY_OUT from somador4Bits.

Behaviour:
- Reset (async, RST_N=0): state=IDLE; BUSY=0, DONE=0, S=0, CARRY_OUT=0. Internal operand registers, index, carry_reg and c1_reg are cleared. ADD_A=ADD_B=0.
- States: IDLE, ADD, INC, FIN. The adder path is combinational; ADD_C and ADD_CARRY are sampled at the same edge that ends each ADD or INC cycle.
- IDLE:
  - ADD_A=ADD_B=0.
  - On an edge with START=1: latch A and B, idx=0, carry_reg=0, go to ADD.
- ADD:
  - Drive ADD_A=opA[idx], ADD_B=opB[idx].
  - At the edge: result nibble idx=ADD_C, c1_reg=ADD_CARRY.
  - If carry_reg=1: go to INC.
  - Else: carry_reg=ADD_CARRY; if idx=NIBBLES-1 go to FIN, otherwise idx++ and stay in ADD.
- INC:
  - Drive ADD_A=result nibble idx, ADD_B=4'b0001.
  - At the edge: result nibble idx=ADD_C, carry_reg=c1_reg|ADD_CARRY (both cannot be 1). Then go to FIN if idx is last, otherwise idx++ and go to ADD.
- FIN:
  - DONE=1 for exactly this cycle; S=result, CARRY_OUT=carry_reg.
  - ADD_A=ADD_B=0. Go to IDLE unconditionally.
  - START during FIN is ignored. The earliest new accept is the following IDLE cycle.
- Latency: busy cycles = NIBBLES + (number of nibbles entered with carry_reg=1). The range is NIBBLES to 2*NIBBLES-1. DONE is asserted in the cycle after the last busy cycle.
- S and CARRY_OUT update only on entry to FIN. They are not modified during a new operation until its FIN; the result accumulates in an internal register.
- START while BUSY or in FIN is ignored, and A/B changes after capture have no effect.
- Reset asserted mid-operation aborts immediately to the reset values; no DONE is produced.
- BUSY and DONE are never high simultaneously.

Test Plan:
- Reset then idle: RST_N low, then high with START=0 for 5 cycles -> BUSY=0, DONE=0, S=0x0000, CARRY_OUT=0, ADD_A=ADD_B=0 throughout.
- No carries: A=0x1234, B=0x4321, START pulse -> exactly 4 BUSY cycles (no INC), DONE in the 5th cycle, S=0x5555, CARRY_OUT=0.
- Carry ripple: A=0x00FF, B=0x0001 -> state sequence ADD,ADD,INC,ADD,INC,ADD (6 BUSY cycles), then DONE; S=0x0100, CARRY_OUT=0.
- Full overflow: A=0xFFFF, B=0x0001 -> 7 BUSY cycles, S=0x0000, CARRY_OUT=1. A=0xFFFF, B=0xFFFF -> S=0xFFFE, CARRY_OUT=1, 7 BUSY cycles.
- Protocol: START held high and A/B changed during BUSY -> result matches the captured operands; exactly one DONE per accepted START; S stays stable between DONEs.
- Mid-op reset: RST_N low during the 3rd BUSY cycle of 0x00FF+0x0001 -> BUSY, DONE, S, CARRY_OUT go to 0 immediately. A fresh START afterwards with 0x0F0F+0x0101 gives S=0x1010, CARRY_OUT=0.

Source files
------------

// File: rtl/somador_serial_ctrl_if.sv
// Handshake and 4-bit adder bus for the nibble-serial adder controller.
// The master side is the environment: it is the requester and also hosts the external adder.
interface somador_serial_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             carry_out;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic [3:0]       add_c;
    logic             add_carry;

    modport master (
        output start, a, b, add_c, add_carry,
        input  busy, done, s, carry_out, add_a, add_b
    );

    modport slave (
        input  start, a, b, add_c, add_carry,
        output busy, done, s, carry_out, add_a, add_b
    );
endinterface

// File: rtl/somador_serial_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer driving one shared carry-less 4-bit adder.
// A pending carry costs an extra INC pass that adds 1 to the nibble just produced.
module somador_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    somador_serial_ctrl_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, INC, FIN} state_t;

    state_t                   state, state_nxt;
    logic [NIBBLES-1:0][3:0]  op_a, op_b, res, res_nxt;
    logic [IDXW-1:0]          idx;
    logic                     carry_reg, carry_nxt, c1_reg;
    logic [WIDTH-1:0]         s_reg;
    logic                     cout_reg;
    logic                     last;

    assign last = (idx == IDXW'(NIBBLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = ADD;
            ADD:  if (carry_reg) state_nxt = INC;
                  else if (last) state_nxt = FIN;
            INC:  state_nxt = last ? FIN : ADD;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.add_a = 4'd0;
        bus.add_b = 4'd0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            ADD: begin
                bus.add_a = op_a[idx];
                bus.add_b = op_b[idx];
                bus.busy  = 1'b1;
            end
            INC: begin
                bus.add_a = res[idx];
                bus.add_b = 4'b0001;
                bus.busy  = 1'b1;
            end
            FIN:     bus.done = 1'b1;
            default: ;
        endcase
    end

    // Accumulator view after this cycle's adder result lands; feeds both res and the FIN snapshot.
    always_comb begin
        res_nxt   = res;
        carry_nxt = carry_reg;
        if (state == ADD) begin
            res_nxt[idx] = bus.add_c;
            if (!carry_reg) carry_nxt = bus.add_carry;
        end else if (state == INC) begin
            res_nxt[idx] = bus.add_c;
            carry_nxt    = c1_reg | bus.add_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            c1_reg    <= 1'b0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_a      <= bus.a;
                    op_b      <= bus.b;
                    idx       <= '0;
                    carry_reg <= 1'b0;
                end
                ADD: begin
                    res       <= res_nxt;
                    carry_reg <= carry_nxt;
                    c1_reg    <= bus.add_carry;
                    // With a pending carry, INC finishes this nibble before idx moves on
                    if (!carry_reg && !last) idx <= idx + IDXW'(1);
                end
                INC: begin
                    res       <= res_nxt;
                    carry_reg <= carry_nxt;
                    if (!last) idx <= idx + IDXW'(1);
                end
                default: ;
            endcase
            if (state_nxt == FIN) begin
                s_reg    <= res_nxt;
                cout_reg <= carry_nxt;
            end
        end
    end

    assign bus.s         = s_reg;
    assign bus.carry_out = cout_reg;
endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Scoreboard bench: stimulus pushes expected sums/latencies, a negedge monitor pops on DONE.
module tb_somador_serial_ctrl;
    typedef struct {
        logic [15:0] s;
        logic        c;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    int   bcnt = 0;
    logic [15:0] last_s = '0;
    logic        last_c = 1'b0;

    somador_serial_ctrl_if #(.WIDTH(16)) bus ();

    somador_serial_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External somador4Bits: combinational 4-bit add, no carry-in
    assign {bus.add_carry, bus.add_c} = 5'(bus.add_a) + 5'(bus.add_b);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer addition; one extra cycle per nibble that receives a carry
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
        exp_t m;
        int unsigned sum, lo;
        sum   = int'(av) + int'(bv);
        m.s   = sum[15:0];
        m.c   = sum[16];
        m.cyc = 4;
        for (int i = 1; i < 4; i++) begin
            lo = 32'd1 << (4 * i);
            if ((int'(av) % lo) + (int'(bv) % lo) >= lo) m.cyc++;
        end
        return m;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            bcnt   = 0;
            last_s = '0;
            last_c = 1'b0;
        end else begin
            if (bus.busy && bus.done) chk("busy_and_done", 1, 0);
            if (bus.busy) bcnt++;
            else chk("adder_idle_zero", {bus.add_a, bus.add_b}, 0);
            if (bus.done) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", bus.s, e.s);
                    chk("carry_out", bus.carry_out, e.c);
                    chk("busy_cycles", bcnt, e.cyc);
                end
                last_s = bus.s;
                last_c = bus.carry_out;
                bcnt   = 0;
            end else begin
                chk("s_stable", {bus.carry_out, bus.s}, {last_c, last_s});
            end
        end
    end

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input bit hold);
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        q.push_back(model(av, bv));
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic run_to_done(input bit hold);
        int n = 0;
        do begin
            @(negedge clk);
            if (hold) begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
            end
            n++;
        end while (!bus.done && n < 50);
        chk("done_seen", bus.done, 1);
        // Holding START through FIN must not start a second operation
        if (hold) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic op(input logic [15:0] av, input logic [15:0] bv, input bit hold);
        issue(av, bv, hold);
        run_to_done(hold);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_s", bus.s, 0);
            chk("rst_cout", bus.carry_out, 0);
        end

        op(16'h1234, 16'h4321, 0);
        op(16'h00FF, 16'h0001, 0);
        op(16'hFFFF, 16'h0001, 0);
        op(16'hFFFF, 16'hFFFF, 0);
        op(16'h8421, 16'h7BDF, 1);
        op(16'h0000, 16'h0000, 1);
        for (int i = 0; i < 20; i++)
            op(16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));

        // Abort mid-operation during the 3rd busy cycle
        issue(16'h00FF, 16'h0001, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_s", bus.s, 0);
        chk("abort_cout", bus.carry_out, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        op(16'h0F0F, 16'h0101, 0);
        repeat (4) @(negedge clk);
        chk("all_done_consumed", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
